// File: rtl/oled_frame_scheduler.sv
// Pixel-slot sequencer for a WIDTH x HEIGHT OLED with frame-granular round-robin sharing of two sources.
// Define OLED_SCHED_TESTPAT_EN to emit a colour bar instead of black when no source owns the frame.
module oled_frame_scheduler #(
  parameter int DIV     = 16,
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int COLOR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               req_a,
  input  logic               req_b,
  input  logic [COLOR_W-1:0] color_a,
  input  logic [COLOR_W-1:0] color_b,
  output logic               slow_clock,
  output logic               pix_tick,
  output logic [12:0]        pixel_index,
  output logic [6:0]         pixel_x,
  output logic [5:0]         pixel_y,
  output logic [COLOR_W-1:0] pixel_data,
  output logic               frame_start,
  output logic               grant_a,
  output logic               grant_b,
  output logic               busy
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int          CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [12:0] LAST_IDX = 13'(WIDTH * HEIGHT - 1);
  localparam logic [6:0]  LAST_X   = 7'(WIDTH - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               slow_q, slow_d;
  logic               tick_q, tick_d;
  state_t             state_q, state_d;
  logic [12:0]        idx_q, idx_d;
  logic [6:0]         x_q, x_d;
  logic [5:0]         y_q, y_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               fs_q, fs_d;
  logic               ga_q, ga_d;
  logic               gb_q, gb_d;
  logic               last_b_q, last_b_d;

  logic               arb_a, arb_b;
  logic [COLOR_W-1:0] idle_color;

  // A tie goes to whichever source did not own the previous granted frame.
  assign arb_a = req_a & (~req_b | last_b_q);
  assign arb_b = req_b & (~req_a | ~last_b_q);

`ifdef OLED_SCHED_TESTPAT_EN
  always_comb begin
    case (x_q[6:5])
      2'd0:    idle_color = COLOR_W'(16'hF800);
      2'd1:    idle_color = COLOR_W'(16'h07E0);
      2'd2:    idle_color = COLOR_W'(16'h001F);
      default: idle_color = COLOR_W'(16'hFFFF);
    endcase
  end
`else
  assign idle_color = '0;
`endif

  always_comb begin
    // NOTE: every _d starts from its _q (or a fixed value) so no path leaves it unassigned and no latch is inferred.
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    slow_d   = (cnt_d >= CNT_HALF);
    tick_d   = (cnt_q == CNT_LAST);
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    data_d   = data_q;
    fs_d     = 1'b0;
    ga_d     = ga_q;
    gb_d     = gb_q;
    last_b_d = last_b_q;

    case (state_q)
      IDLE: begin
        idx_d = '0;
        x_d   = '0;
        y_d   = '0;
        ga_d  = 1'b0;
        gb_d  = 1'b0;
        if (tick_q && enable) begin
          state_d = ACTIVE;
          fs_d    = 1'b1;
          ga_d    = arb_a;
          gb_d    = arb_b;
          if (arb_a || arb_b) last_b_d = arb_b;
        end
      end
      ACTIVE: begin
        if (tick_q) begin
          data_d = ga_q ? color_a : (gb_q ? color_b : idle_color);
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            x_d   = '0;
            y_d   = '0;
            if (enable) begin
              fs_d = 1'b1;
              ga_d = arb_a;
              gb_d = arb_b;
              if (arb_a || arb_b) last_b_d = arb_b;
            end else begin
              state_d = IDLE;
              ga_d    = 1'b0;
              gb_d    = 1'b0;
            end
          end else begin
            idx_d = idx_q + 13'd1;
            if (x_q == LAST_X) begin
              x_d = '0;
              y_d = y_q + 6'd1;
            end else begin
              x_d = x_q + 7'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      slow_q   <= 1'b0;
      tick_q   <= 1'b0;
      state_q  <= IDLE;
      idx_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      data_q   <= '0;
      fs_q     <= 1'b0;
      ga_q     <= 1'b0;
      gb_q     <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      slow_q   <= slow_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      x_q      <= x_d;
      y_q      <= y_d;
      data_q   <= data_d;
      fs_q     <= fs_d;
      ga_q     <= ga_d;
      gb_q     <= gb_d;
      last_b_q <= last_b_d;
    end
  end

  assign slow_clock  = slow_q;
  assign pix_tick    = tick_q;
  assign pixel_index = idx_q;
  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign pixel_data  = data_q;
  assign frame_start = fs_q;
  assign grant_a     = ga_q;
  assign grant_b     = gb_q;
  assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_oled_frame_scheduler.sv
// Bench for oled_frame_scheduler on a reduced 8x4 panel: directed sequences, an arbitration table,
// and randomized traffic compared every cycle against a slot-level reference model.
module tb_oled_frame_scheduler;

  localparam int DIV   = 16;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int NPIX  = W * H;
  localparam int FRAME = NPIX * DIV;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, req_a = 1'b0, req_b = 1'b0;
  logic [15:0] color_a, color_b;
  logic        slow_clock, pix_tick, frame_start, grant_a, grant_b, busy;
  logic [12:0] pixel_index;
  logic [6:0]  pixel_x;
  logic [5:0]  pixel_y;
  logic [15:0] pixel_data;

  logic        col_mode = 1'b0;
  logic [15:0] ca_const = 16'h1234;
  logic [15:0] cb_const = 16'h5678;

  int n_chk  = 0;
  int n_pass = 0;

  // Sources are combinational from the displayed pixel index.
  assign color_a = col_mode ? (16'hA000 | {3'b0, pixel_index}) : ca_const;
  assign color_b = col_mode ? (16'hB000 | {3'b0, pixel_index}) : cb_const;

  always #5 clk = ~clk;

  oled_frame_scheduler #(.DIV(DIV), .WIDTH(W), .HEIGHT(H), .COLOR_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_a(req_a), .req_b(req_b),
    .color_a(color_a), .color_b(color_b), .slow_clock(slow_clock), .pix_tick(pix_tick),
    .pixel_index(pixel_index), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_data(pixel_data),
    .frame_start(frame_start), .grant_a(grant_a), .grant_b(grant_b), .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({slow_clock, pix_tick, pixel_index, pixel_x, pixel_y, pixel_data,
                frame_start, grant_a, grant_b, busy});
  endfunction

  // Reference model: elapsed-cycle counter plus a per-slot frame walk; owner 0=none 1=A 2=B.
  int          m_t = 0, m_idx = 0, m_own = 0, m_last = 2;
  bit          m_active = 0, m_fs = 0, m_valid = 0;
  logic [15:0] m_data = '0;

  function automatic logic [15:0] src_colour(input int src, input int idx);
    if (src == 1) return col_mode ? (16'hA000 | 16'(idx)) : ca_const;
    if (src == 2) return col_mode ? (16'hB000 | 16'(idx)) : cb_const;
    return 16'h0000;
  endfunction

  function automatic int pick_owner(input bit ra, input bit rb, input int last);
    if (ra && rb) return (last == 2) ? 1 : 2;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_idx = 0; m_own = 0; m_last = 2;
      m_active = 0; m_fs = 0; m_data = '0; m_valid = 1;
    end else begin
      m_fs = 0;
      if (m_t > 0 && m_t % DIV == 0) begin
        if (!m_active) begin
          if (enable) begin
            m_active = 1; m_idx = 0; m_fs = 1;
            m_own = pick_owner(req_a, req_b, m_last);
            if (m_own != 0) m_last = m_own;
          end
        end else begin
          m_data = src_colour(m_own, m_idx);
          if (m_idx == NPIX - 1) begin
            m_idx = 0;
            if (enable) begin
              m_fs = 1;
              m_own = pick_owner(req_a, req_b, m_last);
              if (m_own != 0) m_last = m_own;
            end else begin
              m_active = 0; m_own = 0;
            end
          end else begin
            m_idx++;
          end
        end
      end
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model", dut_vec(),
            64'({((m_t % DIV) >= DIV / 2), (m_t > 0 && m_t % DIV == 0), 13'(m_idx),
                 7'(m_idx % W), 6'(m_idx / W), m_data, m_fs, (m_own == 1), (m_own == 2), m_active}));
    end
  end

  task automatic wait_fs(input string name);
    bit ok = 0;
    for (int i = 0; i < FRAME + 2 * DIV; i++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_idx(input int v, input string name);
    bit ok = 0;
    for (int i = 0; i < FRAME + 2 * DIV; i++) begin
      @(negedge clk);
      if (pixel_index == 13'(v)) begin ok = 1; break; end
    end
    check(name, 64'(ok), 64'd1);
  endtask

  typedef struct { bit ra, rb, ga, gb; } arb_vec_t;
  arb_vec_t tbl[7];

  initial begin
    int first_tick, first_slow, ticks, max_idx, fs_cnt;
    bit idx_moved, busy_seen;

    // Arbitration table, applied with last owner = A (after two A-only frames).
    tbl[0] = '{1, 1, 0, 1};
    tbl[1] = '{1, 1, 1, 0};
    tbl[2] = '{1, 1, 0, 1};
    tbl[3] = '{0, 0, 0, 0};
    tbl[4] = '{1, 1, 1, 0};
    tbl[5] = '{0, 1, 0, 1};
    tbl[6] = '{1, 0, 1, 0};

    repeat (2) @(negedge clk);
    check("reset_outputs", dut_vec(), 64'd0);

    // Idle cadence with enable low.
    reset = 1'b0;
    first_tick = 0; first_slow = 0; ticks = 0; idx_moved = 0; busy_seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (pix_tick) begin ticks++; if (first_tick == 0) first_tick = c; end
      if (slow_clock && first_slow == 0) first_slow = c;
      if (pixel_index != 0) idx_moved = 1;
      if (busy) busy_seen = 1;
    end
    check("first_tick_cycle", 64'(first_tick), 64'd16);
    check("first_slow_high", 64'(first_slow), 64'd8);
    check("tick_count_40", 64'(ticks), 64'd2);
    check("idle_index_held", 64'(idx_moved), 64'd0);
    check("idle_busy", 64'(busy_seen), 64'd0);

    // Single requester A over a full frame.
    enable = 1; req_a = 1; req_b = 0;
    wait_fs("fs_first_frame");
    check("a_only_grants", {grant_a, grant_b, busy, pixel_index}, {3'b101, 13'd0});
    max_idx = 0; fs_cnt = 0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      if (int'(pixel_index) > max_idx) max_idx = int'(pixel_index);
      if (frame_start) fs_cnt++;
    end
    check("frame_wrap_fs", {frame_start, pixel_index}, {1'b1, 13'd0});
    check("fs_once_per_frame", 64'(fs_cnt), 64'd1);
    check("max_index", 64'(max_idx), 64'(NPIX - 1));
    check("a_pixel_data", pixel_data, 16'h1234);

    // Table-driven round-robin across frames.
    for (int k = 0; k < 7; k++) begin
      req_a = tbl[k].ra; req_b = tbl[k].rb;
      wait_fs($sformatf("tbl_fs_%0d", k));
      check($sformatf("tbl_grant_%0d", k), {grant_a, grant_b}, {tbl[k].ga, tbl[k].gb});
    end

    // B owns the frame and keeps it after dropping its request mid-frame.
    req_a = 1; req_b = 1;
    wait_fs("drop_fs");
    check("drop_grant_b", {grant_a, grant_b}, 2'b01);
    wait_idx(NPIX / 2, "drop_mid");
    req_b = 0;
    wait_idx(NPIX - 1, "drop_last");
    check("drop_b_held", {grant_a, grant_b}, 2'b01);
    wait_fs("drop_next_fs");
    check("drop_next_a", {grant_a, grant_b}, 2'b10);

    // No requester: no grants, black pixels.
    req_a = 0; req_b = 0;
    wait_fs("none_fs");
    check("none_grants", {grant_a, grant_b, busy}, 3'b001);
    wait_idx(2, "none_idx2");
    check("none_pixel_data", pixel_data, 16'h0000);

    // Enable dropped mid-frame: frame completes, then idle with no new frame.
    wait_idx(15, "en_drop_idx");
    enable = 0;
    wait_idx(NPIX - 1, "en_drop_last");
    wait_idx(0, "en_drop_wrap");
    check("en_drop_idle", {busy, grant_a, grant_b, frame_start}, 4'b0000);
    busy_seen = 0;
    for (int j = 0; j < 3 * DIV; j++) begin
      @(negedge clk);
      if (busy || frame_start || pixel_index != 0) busy_seen = 1;
    end
    check("en_drop_stays_idle", 64'(busy_seen), 64'd0);

    // Reset mid-frame, then restart with A winning the first tie.
    enable = 1; req_a = 1;
    wait_fs("rst_fs");
    wait_idx(10, "rst_idx10");
    reset = 1;
    @(negedge clk);
    check("mid_reset_outputs", dut_vec(), 64'd0);
    reset = 0; req_b = 1;
    wait_fs("restart_fs");
    check("restart_tie_a", {grant_a, grant_b, pixel_index}, {2'b10, 13'd0});

    // Randomized traffic; the per-cycle model comparison does the checking.
    col_mode = 1;
    for (int j = 0; j < 4000; j++) begin
      @(negedge clk);
      if ($urandom_range(63) == 0) enable = ($urandom_range(3) != 0);
      if ($urandom_range(31) == 0) req_a = 1'($urandom);
      if ($urandom_range(31) == 0) req_b = 1'($urandom);
      reset = ($urandom_range(1999) == 0);
    end
    reset = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
